// File: rtl/mux_arbitrado.sv
// -----------------------------------------------------------------------------
// mux_arbitrado
//   N-channel arbitrated multiplexer with a single registered output stage.
//   Each cycle at most one input channel is granted, either by a fixed select
//   (FIX=1, channel S) or by round-robin starting after the last granted
//   channel (FIX=0). The granted word is captured into Y together with its
//   source index CH. The output stage holds one word and refills on the same
//   edge it drains, so back-to-back traffic runs at one word per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1 (V[i]/R[i] on the input side, YV/YR on the output side). Ready never
//   depends on the valid of the same interface except that R is a one-hot
//   grant that only selects among channels with V set.
//
// Ports
//   clk   in   single clock, rising edge
//   rst_n in   synchronous active-low reset
//   D     in   N*W flattened channel data, channel i = D[i*W +: W]
//   V     in   N   per-channel valid
//   R     out  N   per-channel ready (combinational one-hot grant)
//   FIX   in   1   1 = fixed select via S, 0 = round-robin
//   S     in   SW  channel select in fixed mode (S >= N grants nothing)
//   Y     out  W   registered output data
//   YV    out  1   output valid
//   YR    in   1   downstream ready
//   CH    out  SW  source channel of the word held in Y
//   CNT   out  16  saturating count of output transfers
//                  (present only when MUX_ARBITRADO_STATS_EN is defined)
// -----------------------------------------------------------------------------
module mux_arbitrado #(
  parameter int W = 8,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  D,
  input  logic [N-1:0]    V,
  output logic [N-1:0]    R,
  input  logic            FIX,
  input  logic [SW-1:0]   S,
  output logic [W-1:0]    Y,
  output logic            YV,
  input  logic            YR,
  output logic [SW-1:0]   CH
`ifdef MUX_ARBITRADO_STATS_EN
  ,
  output logic [15:0]     CNT
`endif
);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          yv_q, yv_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          loadable;
  logic [N-1:0]  grant;
  logic [SW-1:0] gidx;
  logic          gvalid;
  logic [W-1:0]  sel_data;
  logic [SW-1:0] rr_idx;

  // Grant decision. Reset is folded into loadable so that no grant is
  // offered (and no input transfer completes) on a reset edge.
  always_comb begin
    loadable = rst_n && (!yv_q || YR);
    grant    = '0;
    gidx     = '0;
    gvalid   = 1'b0;
    rr_idx   = '0;
    if (loadable) begin
      if (FIX) begin
        // Comparing S against every legal index means S >= N matches nothing.
        for (int i = 0; i < N; i++) begin
          if (S == SW'(i) && V[i]) begin
            grant[i] = 1'b1;
            gidx     = SW'(i);
            gvalid   = 1'b1;
          end
        end
      end else begin
        // Scan ptr+1, ptr+2, ... ptr+N (mod N); the last candidate is the
        // previously granted channel itself.
        for (int k = 1; k <= N; k++) begin
          rr_idx = SW'((int'(ptr_q) + k) % N);
          if (!gvalid && V[rr_idx]) begin
            gidx   = rr_idx;
            gvalid = 1'b1;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (gvalid && gidx == SW'(i)) grant[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = D[i*W +: W];
    end
  end

  // Output stage: refill wins over drain, which gives the bubble-free
  // one-word-per-cycle behaviour when both happen on the same edge.
  always_comb begin
    y_d   = y_q;
    ch_d  = ch_q;
    yv_d  = yv_q;
    ptr_d = ptr_q;
    if (gvalid) begin
      y_d   = sel_data;
      ch_d  = gidx;
      yv_d  = 1'b1;
      ptr_d = gidx;
    end else if (yv_q && YR) begin
      yv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      ch_q  <= '0;
      yv_q  <= 1'b0;
      // Pointer at the last channel so the first scan begins at channel 0.
      ptr_q <= SW'(N - 1);
    end else begin
      y_q   <= y_d;
      ch_q  <= ch_d;
      yv_q  <= yv_d;
      ptr_q <= ptr_d;
    end
  end

  assign R  = grant;
  assign Y  = y_q;
  assign YV = yv_q;
  assign CH = ch_q;

`ifdef MUX_ARBITRADO_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (yv_q && YR && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_mux_arbitrado.sv
// -----------------------------------------------------------------------------
// tb_mux_arbitrado
//   Bench for mux_arbitrado (N=4, W=8) plus a small N=3 instance for the
//   out-of-range fixed select. Inputs change on the falling edge; outputs are
//   compared 1 ns later. Expected grants come from a vector table (directed)
//   or a fixed-select model (random); granted words are pushed to exp_q and
//   compared against Y/CH while held, popped when the output transfers.
// -----------------------------------------------------------------------------
module tb_mux_arbitrado;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam logic [N*W-1:0] DATA = 32'h44332211;

  logic            clk;
  logic            rst_n;
  logic [N*W-1:0]  D;
  logic [N-1:0]    V;
  logic [N-1:0]    R;
  logic            FIX;
  logic [SW-1:0]   S;
  logic [W-1:0]    Y;
  logic            YV;
  logic            YR;
  logic [SW-1:0]   CH;

  logic [3*W-1:0]  D3;
  logic [2:0]      V3;
  logic [2:0]      R3;
  logic            FIX3;
  logic [1:0]      S3;
  logic [W-1:0]    Y3;
  logic            YV3;
  logic            YR3;
  logic [1:0]      CH3;

`ifdef MUX_ARBITRADO_STATS_EN
  logic [15:0]     CNT;
  logic [15:0]     CNT3;
`endif

  mux_arbitrado #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .V(V), .R(R), .FIX(FIX), .S(S),
    .Y(Y), .YV(YV), .YR(YR), .CH(CH)
`ifdef MUX_ARBITRADO_STATS_EN
    , .CNT(CNT)
`endif
  );

  mux_arbitrado #(.W(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .D(D3), .V(V3), .R(R3), .FIX(FIX3), .S(S3),
    .Y(Y3), .YV(YV3), .YR(YR3), .CH(CH3)
`ifdef MUX_ARBITRADO_STATS_EN
    , .CNT(CNT3)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SW+W-1:0] exp_q[$];
  logic            m_yv;

  typedef struct {
    logic [N-1:0]  v;
    logic          fix;
    logic [SW-1:0] s;
    logic          yr;
    logic [N-1:0]  exp_r;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at falling edge, compare, update the scoreboard model.
  task automatic step(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic fix,
                      input logic [SW-1:0] s, input logic yr, input logic [N-1:0] exp_r);
    logic [SW+W-1:0] w;
    @(negedge clk);
    D = d; V = v; FIX = fix; S = s; YR = yr;
    #1;
    check("R", R, exp_r);
    check("YV", YV, m_yv);
    if (m_yv) begin
      w = exp_q[0];
      check("CH_Y", {CH, Y}, w);
      if (yr) void'(exp_q.pop_front());
    end
    for (int i = 0; i < N; i++)
      if (exp_r[i]) exp_q.push_back({SW'(i), d[i*W +: W]});
    m_yv = (exp_r != '0) || (m_yv && !yr);
  endtask

  // Two reset cycles with the given valids offered; R must stay 0.
  task automatic do_reset(input logic [N-1:0] v);
    @(negedge clk);
    rst_n = 1'b0; V = v; YR = 1'b1; FIX = 1'b0; D = DATA;
    #1;
    check("R_in_reset", R, '0);
    @(negedge clk);
    #1;
    check("R_in_reset", R, '0);
    check("YV_reset", YV, 1'b0);
    check("Y_reset", Y, '0);
    check("CH_reset", CH, '0);
    rst_n = 1'b0;
    rst_n = 1'b1;
    V = '0;
    exp_q.delete();
    m_yv = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] rd;
    logic [N-1:0]   rv, er;
    logic [SW-1:0]  rs;
    logic           ryr;

    // {v, fix, s, yr, exp_r}; state starts empty with pointer at channel 3
    tbl[0]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001};  // rr 0
    tbl[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010};  // rr 1
    tbl[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100};  // rr 2
    tbl[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000};  // rr 3
    tbl[4]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001};  // rr wraps to 0
    tbl[5]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010};  // load 22
    tbl[6]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};  // stall holding 22
    tbl[7]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[8]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100};  // drain + refill same edge
    tbl[10] = '{4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001};  // grant 0
    tbl[11] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b1000};  // then 3
    tbl[12] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b0001};  // wrap to 0
    tbl[13] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100};  // fixed S=2
    tbl[14] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100};
    tbl[15] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100};
    tbl[16] = '{4'b1101, 1'b1, 2'd1, 1'b1, 4'b0000};  // fixed on invalid channel
    tbl[17] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};  // idle
    tbl[18] = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100};  // empty loads with YR=0
    tbl[19] = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};  // full and stalled
    tbl[20] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};  // drain

    rst_n = 1'b0; D = DATA; V = '0; FIX = 1'b0; S = '0; YR = 1'b1;
    D3 = 24'h332211; V3 = '0; FIX3 = 1'b0; S3 = '0; YR3 = 1'b1;
    m_yv = 1'b0;

    do_reset(4'b1111);

    for (int t = 0; t < 21; t++)
      step(DATA, tbl[t].v, tbl[t].fix, tbl[t].s, tbl[t].yr, tbl[t].exp_r);

    // random fixed-select traffic with backpressure
    for (int t = 0; t < 40; t++) begin
      rd  = $urandom;
      rv  = N'($urandom_range(0, 15));
      rs  = SW'($urandom_range(0, 3));
      ryr = 1'($urandom_range(0, 1));
      er  = '0;
      if ((!m_yv || ryr) && rv[rs]) er[rs] = 1'b1;
      step(rd, rv, 1'b1, rs, ryr, er);
    end
    step(DATA, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000);

    // N=3: select 3 is out of range and grants nothing
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      FIX3 = 1'b1; S3 = 2'd3; V3 = 3'b111; YR3 = 1'b1;
      #1;
      check("R3_oor", R3, 3'b000);
      check("YV3_oor", YV3, 1'b0);
    end
    V3 = '0;

    // reset while a word is held
    step(DATA, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0001);
    @(negedge clk);
    rst_n = 1'b0; V = 4'b1111; YR = 1'b1; FIX = 1'b0;
    #1;
    check("R_midreset", R, '0);
    check("YV_before_reset", YV, 1'b1);
    @(posedge clk);
    #1;
    check("YV_midreset", YV, 1'b0);
    check("Y_midreset", Y, '0);
    check("CH_midreset", CH, '0);
    @(negedge clk);
    rst_n = 1'b1; V = '0;
    exp_q.delete();
    m_yv = 1'b0;
    step(DATA, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001);
    step(DATA, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000);

`ifdef MUX_ARBITRADO_STATS_EN
    do_reset(4'b0000);
    #1;
    check("CNT_reset", CNT, 16'd0);
    for (int t = 0; t < 5; t++)
      step(DATA, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001);
    step(DATA, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000);
    @(negedge clk);
    #1;
    check("CNT_5", CNT, 16'd5);
    V = 4'b1111; FIX = 1'b0; YR = 1'b1;
    repeat (65540) @(negedge clk);
    #1;
    check("CNT_sat", CNT, 16'hFFFF);
    V = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
